// File: rtl/timer_pkg.sv
// Shared types and defaults for the loadable countdown timer.
package timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_t;

    localparam int TIMER_BIT_COUNT = 32;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot or auto-reload terminal-count tick.
// Load handshake: a load is taken on any cycle where load_valid && load_ready;
// load_valid without load_ready is dropped, never queued.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int BIT_COUNT = TIMER_BIT_COUNT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [BIT_COUNT-1:0] load_value,
    input  logic                 auto_reload,
    input  logic                 enable,
    input  logic                 abort,
    output logic [BIT_COUNT-1:0] count,
    output logic                 busy,
    output logic                 tick
);

    timer_state_t         state;
    timer_state_t         state_next;
    logic [BIT_COUNT-1:0] count_next;
    logic [BIT_COUNT-1:0] reload;
    logic [BIT_COUNT-1:0] reload_next;
    logic                 mode;
    logic                 mode_next;
    logic                 tick_next;
    logic                 accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            reload <= '0;
            mode   <= 1'b0;
            busy   <= 1'b0;
            tick   <= 1'b0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            reload <= reload_next;
            mode   <= mode_next;
            busy   <= (state_next == RUN);
            tick   <= tick_next;
        end
    end

    always_comb begin
        state_next  = state;
        count_next  = count;
        reload_next = reload;
        mode_next   = mode;
        tick_next   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    count_next  = load_value;
                    reload_next = load_value;
                    mode_next   = auto_reload;
                    // A zero load completes immediately without ever running.
                    if (load_value == '0) begin
                        tick_next = 1'b1;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    count_next = '0;
                    state_next = IDLE;
                end else if (enable) begin
                    if (count > BIT_COUNT'(1)) begin
                        count_next = count - BIT_COUNT'(1);
                    end else if (count == BIT_COUNT'(1)) begin
                        tick_next = 1'b1;
                        if (mode) begin
                            count_next = reload;
                        end else begin
                            count_next = '0;
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_ready = (state == IDLE) && !reset;
        accept     = load_valid && load_ready;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter that produces terminal-count strobes for the Sigma Delta DAQ, e.g. decimation-window and sample-period ticks. It is the complement of the free-running up counter: a value is loaded through a valid/ready handshake, counted down under `enable`, and a one-cycle `tick` is signalled on reaching zero. In one-shot mode it then idles. In auto-reload mode it restarts from the loaded value.

## Interface
- `BIT_COUNT`, default 32, width of `load_value` and `count`.

- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `load_valid`  in  1  load request.
- `load_ready`  out  1  block can accept a load.
- `load_value`  in  BIT_COUNT  start/reload value N; sampled on handshake.
- `auto_reload`  in  1  mode; sampled on handshake. 1 = periodic, 0 = one-shot.
- `enable`  in  1  decrement gate while running.
- `abort`  in  1  stop a running count.
- `count`  out  BIT_COUNT  current count.
- `busy`  out  1  high in RUN.
- `tick`  out  1  one-cycle terminal-count strobe.

## Operation
- States are IDLE and RUN.
- All outputs are registered except `load_ready`, which is combinational: `(state == IDLE) && !reset`.
- Reset values: state IDLE, `count` 0, `busy` 0, `tick` 0, reload register 0, mode register 0.
- Handshake: a load is accepted on a cycle where `load_valid && load_ready`.
  - On acceptance, `count` and the reload register take `load_value`, and the mode register takes `auto_reload`.
  - `load_valid` without `load_ready` is ignored; nothing is queued.
- Accepted N > 0: the next state is RUN and `busy` = 1.
- Accepted N = 0: the state stays IDLE and `tick` = 1 in the next cycle. No RUN is entered, even when `auto_reload` = 1.
- RUN with `enable` = 1 and `count` > 1: `count` decrements by 1.
- RUN with `enable` = 0: `count` holds and no tick is produced.
- RUN, `enable` = 1, `count` == 1 (terminal):
  - One-shot: `count` goes to 0, the state goes to IDLE, `busy` goes to 0 and `tick` = 1, all at the same edge.
  - Auto-reload: `count` reloads to N, the state stays RUN and `tick` = 1.
- `abort` in RUN: `count` goes to 0, the state goes to IDLE and `busy` goes to 0. No tick is produced, and abort wins over a same-cycle terminal count.
- `abort` in IDLE has no effect. A same-cycle `load_valid` in IDLE is still accepted.
- Arithmetic is unsigned. `count` never decrements below 0 and never wraps.
- `tick` is 0 in every cycle not listed above.

## Timing
- Load to RUN: `busy` is high 1 cycle after the handshake cycle.
- With `enable` held high, `tick` occurs N cycles after `busy` rises:
  - In one-shot mode, `count` reads 0 in the `tick` cycle.
  - In auto-reload mode, `count` reads N in the `tick` cycle.
  - The tick period in auto-reload mode is exactly N enabled cycles.
- A gated cycle (`enable` = 0) stretches the interval by exactly 1 cycle.
- One-shot:
  - `load_ready` is high in the `tick` cycle, so a back-to-back reload is possible.
  - The minimum handshake-to-handshake interval is N+1 cycles.
- `reset` asserted mid-count: all state returns to reset values at that edge, with no tick. `load_ready` is 0 during `reset` and 1 in the first cycle after.

## Structure
- Shared package `timer_pkg`:
  - typedef `timer_state_t` (IDLE, RUN).
  - default width constant `TIMER_BIT_COUNT` = 32.
- Single module with no sub-module. The state register, count/reload registers and the registered tick fit naturally in one `always_ff` with a small next-state `always_comb`.

## Test plan
- Reset, then load N=4, auto_reload=0, enable=1:
  - `busy` rises 1 cycle after the handshake.
  - `count` runs 4,3,2,1,0.
  - `tick` is high once, with count 0 and busy 0, 4 cycles after `busy` rises.
  - `load_ready` returns to 1.
- Load N=3, auto_reload=1, enable=1 for 10 cycles:
  - `tick` at cycles 3, 6 and 9 after `busy` rises.
  - `count` reads 3 in each tick cycle.
- Load N=5 with `enable` low for 2 cycles mid-count: `count` holds over those cycles and `tick` arrives 7 cycles after `busy` rises.
- Load N=0:
  - `tick` is high 1 cycle after the handshake.
  - `busy` stays 0 and `load_ready` stays 1.
  - Repeat with auto_reload=1: exactly one tick.
- Abort at the terminal cycle (count == 1, enable = 1): no tick, `count` 0, `busy` 0. Then abort plus load N=2 in IDLE: the load is accepted.
- `reset` asserted while count=7 in RUN:
  - Next cycle `count` 0, `busy` 0, `tick` 0.
  - `load_ready` is 0 during reset and 1 after.
  - A `load_valid` held through reset is accepted only after reset deasserts.
